uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART serial transmitter, 8N1 frame (1 start, 8 data LSB-first, no parity, 1 stop).
//   Takes one byte per valid/ready handshake from a parallel producer and drives it
//   onto the txd line at the configured baud rate. Sits between on-chip logic and the pin.
// PARAMETERS
//   clk_hz     50_000_000  input clock frequency in Hz
//   baud_rate  115_200     serial bit rate in bits/s
//   (derived localparam CLKS_PER_BIT = clk_hz / baud_rate, integer-truncated; 434 at defaults;
//    must be >= 2, elaborate-time error otherwise)
// PORTS
//   clk       in   1  single clock; all state updates on posedge
//   rst       in   1  asynchronous, active-high reset
//   tx_valid  in   1  producer has a byte on tx_data
//   tx_data   in   8  byte to send; sampled only on accept
//   tx_ready  out  1  transmitter idle, can accept a byte this cycle
//   txd       out  1  serial output line, idle high
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, txd=1, tx_ready=1, counters=0,
//     shift register=0. Reset mid-frame aborts immediately; txd returns high, no glitch low.
//   - Accept: on posedge with tx_valid && tx_ready -> latch tx_data into shift reg,
//     go to START; tx_ready=0 from the next cycle. tx_valid while tx_ready=0 is ignored
//     (no queueing); tx_data changes after accept do not affect the frame.
//   - States: IDLE -> START -> DATA(bit 0..7) -> STOP -> IDLE.
//   - Each bit period = exactly CLKS_PER_BIT cycles; baud counter counts 0..CLKS_PER_BIT-1,
//     resets to 0 on every bit transition and on accept.
//   - START: txd=0 beginning the cycle after accept, held CLKS_PER_BIT cycles.
//   - DATA: txd = shift_reg[0]; shift right at end of each bit period; 3-bit index counts
//     0..7; after bit 7 go to STOP.
//   - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE with tx_ready=1 next cycle.
//   - Frame length: 10*CLKS_PER_BIT cycles from first low cycle to tx_ready re-assert.
//   - Back-to-back: tx_valid held high yields a new START the cycle after tx_ready is
//     sampled high; minimum gap between frames = 1 idle-high cycle.
//   - txd and tx_ready are registered outputs (no combinational path from inputs).
//   - Counter widths: baud counter $clog2(CLKS_PER_BIT) bits; no wrap beyond terminal count.
// STRUCTURE
//   - Package uart_pkg: state enum (IDLE, START, DATA, STOP), frame constants
//     (DATA_BITS=8, STOP_BITS=1).
//   - One sub-module natural: uart_baud_gen (counter, clear input, one-cycle bit_done
//     pulse at CLKS_PER_BIT-1). FSM + shift register stay in uart_tx.
// TESTING
//   1 Reset: rst=1 5 cycles -> txd=1, tx_ready=1 during and after reset.
//   2 Send 0x55 at defaults -> txd = 0,1,0,1,0,1,0,1,0,1, each bit 434 cycles;
//     tx_ready low 4340 cycles, then 1.
//   3 Send 0x00 then 0xFF with tx_valid held high -> two correct frames, one idle cycle
//     between, LSB first.
//   4 Pulse tx_valid with 0xA3 during busy frame -> ignored; only first byte transmitted.
//   5 Assert rst mid DATA bit 4 -> txd=1, tx_ready=1 immediately (async); next send 0x3C
//     produces a clean frame.
//   6 Params clk_hz=1_000_000, baud_rate=250_000 (CLKS_PER_BIT=4) -> send 0x81,
//     each bit exactly 4 cycles, frame 40 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and frame constants for the UART transmitter.
//   uart_state_e  - transmitter FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS     - data bits per frame (8, sent LSB first)
//   STOP_BITS     - stop bits per frame (1)
//   LAST_BIT_IDX  - value of the 3-bit data index on the final data bit
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps to 0; bit_done is high for the single
// cycle in which the count sits at CLKS_PER_BIT-1.
// Ports:
//   clk       in  clock, all state updates on posedge
//   rst       in  asynchronous active-high reset
//   clear     in  hold the counter at 0 (used while the transmitter is idle)
//   bit_done  out one-cycle pulse on the last cycle of each bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // A bit period shorter than two cycles cannot be timed by this counter.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] cnt_r;

  assign bit_done = (cnt_r == CNT_LAST);

  // Baud counter: cleared while idle, wraps at the terminal count, never beyond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear || bit_done) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (1 start, 8 data LSB first, 1 stop).
// Accepts one byte per valid/ready handshake and serialises it on txd.
// Parameters:
//   clk_hz     input clock frequency in Hz
//   baud_rate  serial bit rate; CLKS_PER_BIT = clk_hz / baud_rate (truncated)
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   tx_valid  in   producer has a byte on tx_data
//   tx_data   in   byte to send, sampled only on accept
//   tx_ready  out  idle and able to accept a byte this cycle (registered)
//   txd       out  serial line, idle high (registered)
module uart_tx #(
  parameter int clk_hz    = 50_000_000,
  parameter int baud_rate = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clk_hz / baud_rate;

  // The serialiser below emits exactly one stop bit period.
  if (STOP_BITS != 1) begin : g_bad_stop_bits
    $error("uart_tx: only one stop bit is supported");
  end

  uart_state_e state_r;
  uart_state_e state_next_s;
  logic [7:0]  shift_r;
  logic [7:0]  shift_next_s;
  logic [2:0]  bit_idx_r;
  logic [2:0]  bit_idx_next_s;
  logic        txd_r;
  logic        txd_next_s;
  logic        tx_ready_r;
  logic        tx_ready_next_s;
  logic        accept_s;
  logic        baud_clear_s;
  logic        bit_done_s;

  assign accept_s     = tx_valid && tx_ready_r;
  assign baud_clear_s = (state_r == IDLE);
  assign tx_ready     = tx_ready_r;
  assign txd          = txd_r;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear_s),
    .bit_done (bit_done_s)
  );

  // State register plus registered outputs; reset drives the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      txd_r      <= 1'b1;
      tx_ready_r <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      shift_r    <= shift_next_s;
      bit_idx_r  <= bit_idx_next_s;
      txd_r      <= txd_next_s;
      tx_ready_r <= tx_ready_next_s;
    end
  end

  // Next-state logic: frame sequencing and the data shift register.
  always_comb begin
    state_next_s   = state_r;
    shift_next_s   = shift_r;
    bit_idx_next_s = bit_idx_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s   = START;
          shift_next_s   = tx_data;
          bit_idx_next_s = 3'd0;
        end else begin
          state_next_s   = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_next_s   = DATA;
          bit_idx_next_s = 3'd0;
        end else begin
          state_next_s   = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          shift_next_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == LAST_BIT_IDX) begin
            state_next_s   = STOP;
            bit_idx_next_s = 3'd0;
          end else begin
            state_next_s   = DATA;
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s   = IDLE;
        shift_next_s   = 8'h00;
        bit_idx_next_s = 3'd0;
      end
    endcase
  end

  // Output decode from the upcoming state, so the registered txd/tx_ready
  // change in the same cycle the state does (START low right after accept).
  always_comb begin
    txd_next_s      = 1'b1;
    tx_ready_next_s = 1'b0;
    case (state_next_s)
      IDLE: begin
        txd_next_s      = 1'b1;
        tx_ready_next_s = 1'b1;
      end
      START: begin
        txd_next_s      = 1'b0;
      end
      DATA: begin
        txd_next_s      = shift_next_s[0];
      end
      STOP: begin
        txd_next_s      = 1'b1;
      end
      default: begin
        txd_next_s      = 1'b1;
        tx_ready_next_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
// One instance at default parameters (434 clocks per bit) and one at
// 1 MHz / 250 kBd (4 clocks per bit). Outputs are sampled on the falling edge.
module tb_uart_tx;

  localparam int N  = 434;
  localparam int N4 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       txd;
  logic       tx_valid4;
  logic [7:0] tx_data4;
  logic       tx_ready4;
  logic       txd4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .txd      (txd)
  );

  uart_tx #(
    .clk_hz    (1_000_000),
    .baud_rate (250_000)
  ) dut4 (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid4),
    .tx_data  (tx_data4),
    .tx_ready (tx_ready4),
    .txd      (txd4)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Bounded wait (at falling edges) for the default instance to be ready.
  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (tx_ready !== 1'b1 && cnt < 12 * N) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_ready_wait"}, tx_ready, 1'b1);
  endtask

  // Check one frame cycle by cycle. exp[k] is the k-th bit on the line
  // (start first). The caller raised tx_valid just before the accepting edge.
  task automatic frame_check(input string tag, input logic [9:0] exp,
                             input bit hold, input bit inject);
    for (int i = 0; i < 10 * N; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) tx_valid = 1'b0;
      chk({tag, "_txd"}, txd, exp[i / N]);
      chk({tag, "_busy"}, tx_ready, 1'b0);
      if (inject && i == 1000) begin
        tx_valid = 1'b1;
        tx_data  = 8'hA3;
      end
      if (inject && i == 1001) tx_valid = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, tx_ready, 1'b1);
    chk({tag, "_idle_high"}, txd, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_valid4 = 1'b0;
    tx_data4  = 8'h00;

    // 1: reset held 5 cycles, line idle and ready throughout and afterwards
    repeat (5) begin
      @(negedge clk);
      chk("rst_txd", txd, 1'b1);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_txd4", txd4, 1'b1);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_txd", txd, 1'b1);
    chk("post_rst_ready", tx_ready, 1'b1);

    // 2: 0x55 -> line 0,1,0,1,0,1,0,1,0,1
    wait_ready("f55");
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    frame_check("f55", 10'b1010101010, 1'b0, 1'b0);

    // 3: 0x00 then 0xFF back to back with tx_valid held high
    wait_ready("b2b");
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    frame_check("f00", 10'b1000000000, 1'b1, 1'b0);
    tx_data  = 8'hFF;
    frame_check("fFF", 10'b1111111110, 1'b0, 1'b0);

    // 4: 0xC4 with a 0xA3 pulse mid-frame that must be ignored
    wait_ready("fC4");
    tx_valid = 1'b1;
    tx_data  = 8'hC4;
    frame_check("fC4", 10'b1110001000, 1'b0, 1'b1);
    repeat (20) begin
      @(negedge clk);
      chk("no_queue_txd", txd, 1'b1);
      chk("no_queue_ready", tx_ready, 1'b1);
    end

    // 5: reset in the middle of data bit 4 (line low for 0x00)
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    for (int i = 0; i < 5 * N + 10; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid = 1'b0;
    end
    chk("pre_rst_txd", txd, 1'b0);
    chk("pre_rst_busy", tx_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1'b1);
    chk("async_rst_ready", tx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_txd", txd, 1'b1);
    chk("rst_rel_ready", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    frame_check("f3C", 10'b1001111000, 1'b0, 1'b0);

    // 6: 4 clocks per bit instance sends 0x81, 40-cycle frame
    chk("p4_ready_pre", tx_ready4, 1'b1);
    tx_valid4 = 1'b1;
    tx_data4  = 8'h81;
    for (int i = 0; i < 10 * N4; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid4 = 1'b0;
      case (i / N4)
        0:       chk("p4_txd", txd4, 1'b0);
        1:       chk("p4_txd", txd4, 1'b1);
        8:       chk("p4_txd", txd4, 1'b1);
        9:       chk("p4_txd", txd4, 1'b1);
        default: chk("p4_txd", txd4, 1'b0);
      endcase
      chk("p4_busy", tx_ready4, 1'b0);
    end
    @(negedge clk);
    chk("p4_ready_after", tx_ready4, 1'b1);
    chk("p4_idle_high", txd4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
